// File: rtl/ram_1wnr_sync_if.sv
// Bus bundle for ram_1wnr_sync: one masked write channel plus rd_ports_p
// independent read channels with packed addresses and data.
interface ram_1wnr_sync_if #(
   parameter int width_p    = 32,
   parameter int depth_p    = 128,
   parameter int rd_ports_p = 2
);
   localparam int addr_w = $clog2(depth_p);
   localparam int mask_w = width_p / 8;

   logic                           wr_valid_i;
   logic [addr_w-1:0]              wr_addr_i;
   logic [width_p-1:0]             wr_data_i;
   logic [mask_w-1:0]              wr_mask_i;
   logic [rd_ports_p-1:0]          rd_valid_i;
   logic [rd_ports_p*addr_w-1:0]   rd_addr_i;
   logic [rd_ports_p-1:0]          rd_valid_o;
   logic [rd_ports_p*width_p-1:0]  rd_data_o;

   modport master (
      output wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
      input  rd_valid_o, rd_data_o
   );

   modport slave (
      input  wr_valid_i, wr_addr_i, wr_data_i, wr_mask_i, rd_valid_i, rd_addr_i,
      output rd_valid_o, rd_data_o
   );
endinterface

// File: rtl/ram_1wnr_sync.sv
// 1-write / N-read synchronous RAM with byte-masked write-first forwarding and
// a post-reset clear sequencer. Define RAM_1WNR_SYNC_OUTREG_EN for a 2-cycle read.
module ram_1wnr_sync #(
   parameter int width_p    = 32,
   parameter int depth_p    = 128,
   parameter int rd_ports_p = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   output logic             ready_o,
   ram_1wnr_sync_if.slave   bus
);
   localparam int addr_w = $clog2(depth_p);
   localparam int mask_w = width_p / 8;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

   localparam logic [addr_w:0]   depth_w   = (addr_w + 1)'(depth_p);
   localparam logic [addr_w-1:0] last_addr = addr_w'(depth_p - 1);

   logic [0:0]        state_reg, state_next;
   logic [addr_w-1:0] clr_cnt_reg, clr_cnt_next;
   logic              is_ready;

   logic [width_p-1:0] mem [depth_p];

   assign is_ready = (state_reg == ST_READY);
   assign ready_o  = is_ready;

   always_comb begin
      state_next   = state_reg;
      clr_cnt_next = clr_cnt_reg;
      if (state_reg == ST_CLEAR) begin
         clr_cnt_next = clr_cnt_reg + 1'b1;
         if (clr_cnt_reg == last_addr) state_next = ST_READY;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_reg   <= ST_CLEAR;
         clr_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_cnt_reg <= clr_cnt_next;
      end
   end

   // Single physical write port shared by the clear sequencer and user writes.
   logic               wr_legal;
   logic [width_p-1:0] wr_bitmask;
   logic               mem_we;
   logic [addr_w-1:0]  mem_addr;
   logic [width_p-1:0] mem_wdata;
   logic [mask_w-1:0]  mem_byte_en;

   assign wr_legal = ({1'b0, bus.wr_addr_i} < depth_w);

   for (genvar gi = 0; gi < mask_w; gi++) begin : g_bitmask
      assign wr_bitmask[gi*8 +: 8] = {8{bus.wr_mask_i[gi]}};
   end

   always_comb begin
      mem_we      = 1'b0;
      mem_addr    = bus.wr_addr_i;
      mem_wdata   = bus.wr_data_i;
      mem_byte_en = bus.wr_mask_i;
      if (state_reg == ST_CLEAR) begin
         mem_we      = 1'b1;
         mem_addr    = clr_cnt_reg;
         mem_wdata   = '0;
         mem_byte_en = '1;
      end else begin
         mem_we = bus.wr_valid_i && wr_legal && (|bus.wr_mask_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && mem_we) begin
         for (int b = 0; b < mask_w; b++) begin
            if (mem_byte_en[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end
      end
   end

   logic [rd_ports_p-1:0]         rd_valid_q1;
   logic [rd_ports_p*width_p-1:0] rd_data_q1;

   for (genvar gi = 0; gi < rd_ports_p; gi++) begin : g_rd
      logic [addr_w-1:0]  ra;
      logic               ra_legal;
      logic               fwd;
      logic               take;
      logic [width_p-1:0] rd_word;
      logic               valid_reg;
      logic [width_p-1:0] data_reg;

      assign ra       = bus.rd_addr_i[gi*addr_w +: addr_w];
      assign ra_legal = ({1'b0, ra} < depth_w);
      assign fwd      = bus.wr_valid_i && wr_legal && (bus.wr_addr_i == ra);
      assign take     = is_ready && bus.rd_valid_i[gi];

      // Write-first: a same-cycle write to this address is merged bytewise.
      always_comb begin
         rd_word = '0;
         if (ra_legal) begin
            rd_word = fwd ? ((mem[ra] & ~wr_bitmask) | (bus.wr_data_i & wr_bitmask))
                          : mem[ra];
         end
      end

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
         end else begin
            valid_reg <= take;
            if (take) data_reg <= rd_word;
         end
      end

      assign rd_valid_q1[gi]                  = valid_reg;
      assign rd_data_q1[gi*width_p +: width_p] = data_reg;
   end

`ifdef RAM_1WNR_SYNC_OUTREG_EN
   for (genvar gi = 0; gi < rd_ports_p; gi++) begin : g_outreg
      logic               valid_q2_reg;
      logic [width_p-1:0] data_q2_reg;

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            valid_q2_reg <= 1'b0;
            data_q2_reg  <= '0;
         end else begin
            valid_q2_reg <= rd_valid_q1[gi];
            data_q2_reg  <= rd_data_q1[gi*width_p +: width_p];
         end
      end

      assign bus.rd_valid_o[gi]                  = valid_q2_reg;
      assign bus.rd_data_o[gi*width_p +: width_p] = data_q2_reg;
   end
`else
   assign bus.rd_valid_o = rd_valid_q1;
   assign bus.rd_data_o  = rd_data_q1;
`endif
endmodule

// File: tb/tb_ram_1wnr_sync.sv
// Directed, table-driven bench for ram_1wnr_sync (32 x 128, 2 read channels),
// covering clear timing, masked writes, forwarding, channel independence and reset.
module tb_ram_1wnr_sync;
`ifdef RAM_1WNR_SYNC_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic ready;

   int n_checks = 0;
   int n_fail   = 0;

   ram_1wnr_sync_if #(.width_p(32), .depth_p(128), .rd_ports_p(2)) bus ();

   ram_1wnr_sync #(.width_p(32), .depth_p(128), .rd_ports_p(2)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .ready_o (ready),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        wr_v;
      logic [6:0]  wr_a;
      logic [31:0] wr_d;
      logic [3:0]  wr_m;
      logic [1:0]  rd_v;
      logic [6:0]  ra0;
      logic [6:0]  ra1;
      logic [1:0]  ev;
      logic [31:0] ed0;
      logic [31:0] ed1;
   } vec_t;

   vec_t vecs [13];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs;
      bus.wr_valid_i = 1'b0;
      bus.wr_addr_i  = '0;
      bus.wr_data_i  = '0;
      bus.wr_mask_i  = '0;
      bus.rd_valid_i = '0;
      bus.rd_addr_i  = '0;
   endtask

   // Present one request for a cycle, then idle until the read result is due.
   task automatic do_op(input logic wv, input logic [6:0] wa, input logic [31:0] wd,
                        input logic [3:0] wm, input logic [1:0] rv,
                        input logic [6:0] a0, input logic [6:0] a1);
      bus.wr_valid_i = wv;
      bus.wr_addr_i  = wa;
      bus.wr_data_i  = wd;
      bus.wr_mask_i  = wm;
      bus.rd_valid_i = rv;
      bus.rd_addr_i  = {a1, a0};
      tick();
      idle_inputs();
`ifdef RAM_1WNR_SYNC_OUTREG_EN
      check("lat2_gap_valid", 96'(bus.rd_valid_o), 96'(0));
      tick();
`endif
   endtask

   function automatic logic [95:0] rd_state;
      return {30'd0, bus.rd_valid_o, bus.rd_data_o[31:0], bus.rd_data_o[63:32]};
   endfunction

   function automatic logic [95:0] exp_state(input logic [1:0] v, input logic [31:0] d0,
                                            input logic [31:0] d1);
      return {30'd0, v, d0, d1};
   endfunction

   initial begin
      //         wr_v  addr  data          mask  rd_v   ra0  ra1  ev     ed0           ed1
      vecs[0]  = '{1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 2'b00, 7'd0,   7'd0,   2'b00, 32'h0,        32'h0};
      vecs[1]  = '{1'b1, 7'd5,   32'h11223344, 4'h5, 2'b00, 7'd0,   7'd0,   2'b00, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 7'd0,   32'h0,        4'h0, 2'b11, 7'd5,   7'd5,   2'b11, 32'hDE22BE44, 32'hDE22BE44};
      vecs[3]  = '{1'b1, 7'd9,   32'hAAAAAAAA, 4'hF, 2'b00, 7'd0,   7'd0,   2'b00, 32'hDE22BE44, 32'hDE22BE44};
      vecs[4]  = '{1'b1, 7'd9,   32'h55555555, 4'h3, 2'b11, 7'd9,   7'd9,   2'b11, 32'hAAAA5555, 32'hAAAA5555};
      vecs[5]  = '{1'b0, 7'd0,   32'h0,        4'h0, 2'b01, 7'd9,   7'd0,   2'b01, 32'hAAAA5555, 32'hAAAA5555};
      vecs[6]  = '{1'b1, 7'd3,   32'h03030303, 4'hF, 2'b00, 7'd0,   7'd0,   2'b00, 32'hAAAA5555, 32'hAAAA5555};
      vecs[7]  = '{1'b1, 7'd7,   32'h07070707, 4'hF, 2'b11, 7'd3,   7'd7,   2'b11, 32'h03030303, 32'h07070707};
      vecs[8]  = '{1'b0, 7'd0,   32'h0,        4'h0, 2'b10, 7'd7,   7'd3,   2'b10, 32'h03030303, 32'h03030303};
      vecs[9]  = '{1'b1, 7'd3,   32'hFFFFFFFF, 4'h0, 2'b01, 7'd3,   7'd5,   2'b01, 32'h03030303, 32'h03030303};
      vecs[10] = '{1'b0, 7'd0,   32'h0,        4'h0, 2'b11, 7'd3,   7'd5,   2'b11, 32'h03030303, 32'hDE22BE44};
      vecs[11] = '{1'b1, 7'd127, 32'hCAFEF00D, 4'h8, 2'b11, 7'd127, 7'd0,   2'b11, 32'hCA000000, 32'h0};
      vecs[12] = '{1'b0, 7'd0,   32'h0,        4'h0, 2'b10, 7'd0,   7'd127, 2'b10, 32'hCA000000, 32'hCA000000};

      rst = 1'b1;
      idle_inputs();
      repeat (3) tick();
      check("reset_ready", 96'(ready), 96'(0));
      check("reset_rd_state", rd_state(), exp_state(2'b00, 32'h0, 32'h0));

      // Clear: requests are presented throughout and must be ignored.
      rst = 1'b0;
      bus.rd_valid_i = 2'b11;
      bus.wr_valid_i = 1'b1;
      bus.wr_mask_i  = 4'hF;
      bus.wr_data_i  = 32'hFFFFFFFF;
      for (int c = 0; c < 128; c++) begin
         check("clear_busy", 96'({ready, bus.rd_valid_o}), 96'(0));
         tick();
      end
      check("clear_done_ready", 96'(ready), 96'(1));
      $display("clear complete ready=%b", ready);

      for (int a = 0; a < 128; a++) begin
         do_op(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'(a), 7'(127 - a));
         check("sweep_zero", rd_state(), exp_state(2'b11, 32'h0, 32'h0));
      end
      $display("sweep read 128 addresses on both channels");

      for (int i = 0; i < 13; i++) begin
         do_op(vecs[i].wr_v, vecs[i].wr_a, vecs[i].wr_d, vecs[i].wr_m,
               vecs[i].rd_v, vecs[i].ra0, vecs[i].ra1);
         $display("vec %0d wr=%b a=%0d d=%h m=%h rd=%b a0=%0d a1=%0d -> v=%b d0=%h d1=%h",
                  i, vecs[i].wr_v, vecs[i].wr_a, vecs[i].wr_d, vecs[i].wr_m, vecs[i].rd_v,
                  vecs[i].ra0, vecs[i].ra1, bus.rd_valid_o, bus.rd_data_o[31:0],
                  bus.rd_data_o[63:32]);
         check($sformatf("vec%0d", i), rd_state(),
               exp_state(vecs[i].ev, vecs[i].ed0, vecs[i].ed1));
      end

      // Back-to-back reads interrupted by a one-cycle reset.
      bus.rd_valid_i = 2'b11;
      bus.rd_addr_i  = {7'd9, 7'd5};
      tick();
`ifndef RAM_1WNR_SYNC_OUTREG_EN
      check("b2b_first", rd_state(), exp_state(2'b11, 32'hDE22BE44, 32'hAAAA5555));
`endif
      bus.rd_addr_i = {7'd5, 7'd9};
      rst = 1'b1;
      tick();
      $display("reset mid-stream v=%b ready=%b", bus.rd_valid_o, ready);
      check("rst_mid_ready", 96'(ready), 96'(0));
      check("rst_mid_rd_state", rd_state(), exp_state(2'b00, 32'h0, 32'h0));
      rst = 1'b0;
      for (int c = 0; c < 128; c++) begin
         check("reclear_busy", 96'({ready, bus.rd_valid_o}), 96'(0));
         tick();
      end
      check("reclear_done_ready", 96'(ready), 96'(1));
      do_op(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'd5, 7'd9);
      $display("post-reset read a0=5 a1=9 -> v=%b d0=%h d1=%h",
               bus.rd_valid_o, bus.rd_data_o[31:0], bus.rd_data_o[63:32]);
      check("reclear_5_9", rd_state(), exp_state(2'b11, 32'h0, 32'h0));
      do_op(1'b0, 7'd0, 32'h0, 4'h0, 2'b11, 7'd3, 7'd127);
      $display("post-reset read a0=3 a1=127 -> v=%b d0=%h d1=%h",
               bus.rd_valid_o, bus.rd_data_o[31:0], bus.rd_data_o[63:32]);
      check("reclear_3_127", rd_state(), exp_state(2'b11, 32'h0, 32'h0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_1wnr_sync.md
# ram_1wnr_sync

Parametrised 1-write / N-read synchronous RAM, the next generation of the team's single-port asynchronous scratchpad RAM. It adds registered reads, independent read channels with valid tracking, and byte-masked writes with write-first forwarding. A self-clearing sequencer zeroes the array after reset. It serves as the operand and accumulator buffer feeding the systolic array, where several PE rows read the same bank each cycle.

## Interface
- width_p, 32: data word width in bits; must be a multiple of 8.
- depth_p, 128: number of words; must be ≥ 2.
- rd_ports_p, 2: number of independent read channels; must be ≥ 1.
- Derived: addr_w = $clog2(depth_p); mask_w = width_p/8.

Ports:
- clk_i  in  1  sole clock, all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- ready_o  out  1  high once the post-reset clear has completed.
- wr_valid_i  in  1  write request this cycle.
- wr_addr_i  in  addr_w  write address.
- wr_data_i  in  width_p  write data.
- wr_mask_i  in  mask_w  byte enables; bit b writes wr_data_i[8b+7:8b].
- rd_valid_i  in  rd_ports_p  per-channel read request.
- rd_addr_i  in  rd_ports_p*addr_w  packed read addresses; channel k uses slice [k*addr_w +: addr_w].
- rd_valid_o  out  rd_ports_p  per-channel read data valid.
- rd_data_o  out  rd_ports_p*width_p  packed read data; channel k uses slice [k*width_p +: width_p].

## Operation
- The block has two states, CLEAR and READY.
- Reset: state is CLEAR and the clear counter is 0. ready_o = 0, rd_valid_o = 0, rd_data_o = 0.
- CLEAR:
  - Each cycle with reset_i low writes all-zero to mem[counter], then increments the counter.
  - After the edge that writes address depth_p-1, the state becomes READY.
  - wr_valid_i and rd_valid_i are ignored; rd_valid_o stays 0.
- READY:
  - Write: if wr_valid_i, bytes of mem[wr_addr_i] with wr_mask_i=1 take wr_data_i; bytes with mask 0 are unchanged.
  - A write with mask all-zero is a no-op.
  - Read: each channel k with rd_valid_i[k]=1 captures its word at the edge.
  - rd_valid_o[k] mirrors rd_valid_i[k] after the read latency.
- Forwarding (write-first): if a channel reads wr_addr_i in the same cycle as wr_valid_i, it returns the merged word. Masked bytes come from wr_data_i; the rest come from the old contents.
- Channels are fully independent. Any number may read the same address in the same cycle.
- rd_data_o[k] holds its last value while rd_valid_o[k]=0. It is never cleared except by reset.
- Addresses ≥ depth_p (non-power-of-two depth) are illegal. Writes to them are dropped; reads from them return 0 with valid asserted.
- Reset asserted mid-operation, in any state:
  - In-flight reads are discarded and rd_valid_o drops at the next edge.
  - The clear restarts from address 0.

## Timing
- Read latency is 1 cycle: request at edge n, data and valid visible after edge n+1 is sampled, i.e. in cycle n+1.
- Write latency is 1 cycle: a read issued in the cycle after a write returns the new data.
- Clear duration is exactly depth_p cycles:
  - Reset deasserted in cycle 0.
  - ready_o = 1 from cycle depth_p.
  - A request presented in cycle depth_p is accepted.
- Throughput: one write plus rd_ports_p reads every cycle, with no stalls once READY.
- ready_o falls at the first edge where reset_i = 1.

## Configuration
- RAM_1WNR_SYNC_OUTREG_EN defined:
  - Adds an output register stage per channel; read latency becomes 2.
  - rd_valid_o and rd_data_o are pipelined identically.
  - Reset clears both stages.
  - Forwarding still applies only to a write in the request cycle. A write in the cycle between request and output is not reflected.
- RAM_1WNR_SYNC_OUTREG_EN undefined: read latency is 1, as specified above.

## Test plan
- Clear: release reset with depth_p=128. ready_o must be low for 128 cycles and rise in cycle 128. Read all addresses on every channel; each must return 0x00000000.
- Masked write: write 0xDEADBEEF to addr 5 with mask 4'b1111, then 0x11223344 with mask 4'b0101. A read of addr 5 must return 0xDE22BE44.
- Forwarding: with mem[9] = 0xAAAAAAAA, write 0x55555555 mask 4'b0011 to addr 9 while channels 0 and 1 read addr 9 in the same cycle. Both must return 0xAAAA5555 one cycle later.
- Independent channels: channel 0 reads addr 3 and channel 1 reads addr 7 in the same cycle; then channel 1 alone reads addr 3. Check each rd_valid_o bit and data slice independently, including that channel 0's idle rd_data_o holds its last value.
- Reset mid-stream: issue back-to-back reads, then assert reset for 1 cycle. rd_valid_o must be 0 at the next edge and ready_o low. The clear must restart and complete 128 cycles after reset release, and previously written data must read back as 0.
- With RAM_1WNR_SYNC_OUTREG_EN defined: repeat the masked-write and forwarding scenarios. Data and valid must appear exactly 2 cycles after the request.
